// File: rtl/pla_sync_array_pkg.sv
// Shared types, pair encodings and width helpers for the programmable logic array.
package pla_pkg;

  typedef enum logic [1:0] {SEL_AND, SEL_OR, SEL_POL, SEL_RSV} cfg_sel_e;
  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_e;

  localparam logic [1:0] PAIR_DC   = 2'b00;
  localparam logic [1:0] PAIR_T    = 2'b01;
  localparam logic [1:0] PAIR_C    = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cfg_w(input int n_in, input int n_term, input int n_out);
    return max3(2 * n_in, n_term, n_out);
  endfunction

  function automatic int addr_w(input int n_term, input int n_out);
    return $clog2(max3(n_term, n_out, 2));
  endfunction

endpackage

// File: rtl/pla_sync_array_if.sv
// Sample stream and configuration port bundle of the PLA.
interface pla_sync_array_if
  import pla_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int N_TERM = 16,
  parameter int N_OUT  = 3
) ();
  localparam int CW = cfg_w(N_IN, N_TERM, N_OUT);
  localparam int AW = addr_w(N_TERM, N_OUT);

  logic [N_IN-1:0]  in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [N_OUT-1:0] out_vec;
  logic             out_valid;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [AW-1:0]    cfg_addr;
  logic [CW-1:0]    cfg_data;
  logic             cfg_commit;
  logic             cfg_done;

  modport master (
    output in_vec, in_valid, cfg_we, cfg_sel, cfg_addr, cfg_data, cfg_commit,
    input  in_ready, out_vec, out_valid, cfg_done
  );

  modport slave (
    input  in_vec, in_valid, cfg_we, cfg_sel, cfg_addr, cfg_data, cfg_commit,
    output in_ready, out_vec, out_valid, cfg_done
  );
endinterface

// File: rtl/pla_sync_array_and_term.sv
// One AND-plane row: two enable bits per input select true/complement literal.
module pla_and_term
  import pla_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic [2*N_IN-1:0] row_i,
  input  logic [N_IN-1:0]   in_i,
  output logic              term_o
);
  always_comb begin
    term_o = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      case (row_i[2*i +: 2])
        PAIR_T:    if (!in_i[i]) term_o = 1'b0;
        PAIR_C:    if (in_i[i])  term_o = 1'b0;
        PAIR_ZERO: term_o = 1'b0;
        default:   ;
      endcase
    end
  end
endmodule

// File: rtl/pla_sync_array.sv
// Two-stage PLA (AND plane -> OR plane + polarity) with shadow config swapped in
// only once the pipeline is empty.
module pla_sync_array
  import pla_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int N_TERM = 16,
  parameter int N_OUT  = 3
) (
  input logic             clk,
  input logic             rst,
  pla_sync_array_if.slave bus
);
  localparam int AW     = addr_w(N_TERM, N_OUT);
  localparam int STAGES = 2;

  logic [N_TERM-1:0][2*N_IN-1:0] and_sh_q, and_act_q;
  logic [N_OUT-1:0][N_TERM-1:0]  or_sh_q, or_act_q;
  logic [N_OUT-1:0]              pol_sh_q, pol_act_q;

  state_e            state_q;
  logic              cfg_done_q;
  logic [STAGES:1]   vld_pipe_q;
  logic [N_TERM-1:0] term, term_q;
  logic [N_OUT-1:0]  out_d, out_vec_q;
  logic              accept, v1_d, ov_d;

  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_vec   = out_vec_q;
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.cfg_done  = cfg_done_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign v1_d   = accept;
  assign ov_d   = vld_pipe_q[1];

  // Shadow rows; the polarity vector is a single row living at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_sh_q <= '0;
      or_sh_q  <= '0;
      pol_sh_q <= '0;
    end else if (bus.cfg_we) begin
      case (cfg_sel_e'(bus.cfg_sel))
        SEL_AND:
          for (int t = 0; t < N_TERM; t++)
            if (bus.cfg_addr == AW'(t)) and_sh_q[t] <= bus.cfg_data[2*N_IN-1:0];
        SEL_OR:
          for (int o = 0; o < N_OUT; o++)
            if (bus.cfg_addr == AW'(o)) or_sh_q[o] <= bus.cfg_data[N_TERM-1:0];
        SEL_POL:
          if (bus.cfg_addr == '0) pol_sh_q <= bus.cfg_data[N_OUT-1:0];
        default: ;
      endcase
    end
  end

  // Non-blocking copy picks up the pre-write shadow when a write lands in SWAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_act_q <= '0;
      or_act_q  <= '0;
      pol_act_q <= '0;
    end else if (state_q == SWAP) begin
      and_act_q <= and_sh_q;
      or_act_q  <= or_sh_q;
      pol_act_q <= pol_sh_q;
    end
  end

  // Leave DRAIN as soon as both stages will be empty next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cfg_done_q <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      case (state_q)
        RUN:   if (bus.cfg_commit) state_q <= DRAIN;
        DRAIN: if (!(v1_d || ov_d)) begin
                 state_q    <= SWAP;
                 cfg_done_q <= 1'b1;
               end
        SWAP:  state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  for (genvar t = 0; t < N_TERM; t++) begin : g_term
    pla_and_term #(.N_IN(N_IN)) u_term (
      .row_i  (and_act_q[t]),
      .in_i   (bus.in_vec),
      .term_o (term[t])
    );
  end

  always_comb begin
    out_d = '0;
    for (int o = 0; o < N_OUT; o++)
      out_d[o] = (|(term_q & or_act_q[o])) ^ pol_act_q[o];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      term_q     <= '0;
      out_vec_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], v1_d};
      if (accept)        term_q    <= term;
      if (vld_pipe_q[1]) out_vec_q <= out_d;
    end
  end
endmodule

// File: tb/tb_pla_sync_array.sv
// Randomized + directed bench for pla_sync_array against a sum-of-products reference model.
module tb_pla_sync_array;
  import pla_pkg::*;

  localparam int N_IN = 8, N_TERM = 16, N_OUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pla_sync_array_if #(.N_IN(N_IN), .N_TERM(N_TERM), .N_OUT(N_OUT)) bus ();

  pla_sync_array #(.N_IN(N_IN), .N_TERM(N_TERM), .N_OUT(N_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, n_lo = 0, n_done = 0;

  logic [2*N_IN-1:0] m_and_sh [N_TERM], m_and_act [N_TERM];
  logic [N_TERM-1:0] m_or_sh [N_OUT], m_or_act [N_OUT];
  logic [N_OUT-1:0]  m_pol_sh, m_pol_act, m_last;
  int                m_busy;   // remaining non-accepting cycles; 1 = the copy cycle
  typedef struct { int due; logic [N_OUT-1:0] val; } exp_t;
  exp_t q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  // A term is true when every selected literal is satisfied; 11 selects both, never satisfied.
  function automatic logic [N_OUT-1:0] model_eval(input logic [N_IN-1:0] v);
    logic [N_OUT-1:0] r;
    logic             term_t;
    logic             want_t, want_c;
    r = '0;
    for (int o = 0; o < N_OUT; o++) begin
      r[o] = 1'b0;
      for (int t = 0; t < N_TERM; t++) begin
        term_t = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
          want_t = m_and_act[t][2*i];
          want_c = m_and_act[t][2*i+1];
          if (want_t && !v[i]) term_t = 1'b0;
          if (want_c && v[i])  term_t = 1'b0;
        end
        if (term_t && m_or_act[o][t]) r[o] = 1'b1;
      end
      r[o] = r[o] ^ m_pol_act[o];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < N_TERM; t++) begin m_and_sh[t] = '0; m_and_act[t] = '0; end
    for (int o = 0; o < N_OUT; o++)  begin m_or_sh[o] = '0;  m_or_act[o] = '0;  end
    m_pol_sh = '0; m_pol_act = '0; m_last = '0; m_busy = 0;
    q.delete();
  endtask

  task automatic step(input logic vld, input logic [N_IN-1:0] vec, input logic we,
                      input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] data,
                      input logic commit);
    logic acc;
    exp_t e;
    bus.in_valid = vld; bus.in_vec = vec; bus.cfg_we = we; bus.cfg_sel = sel;
    bus.cfg_addr = addr; bus.cfg_data = data; bus.cfg_commit = commit;
    chk("in_ready", bus.in_ready, m_busy == 0);
    chk("cfg_done", bus.cfg_done, m_busy == 1);
    if (!bus.in_ready) n_lo++;
    if (bus.cfg_done)  n_done++;
    acc = vld && (m_busy == 0);
    if (acc) q.push_back('{cyc + 2, model_eval(vec)});
    if (m_busy == 1) begin
      for (int t = 0; t < N_TERM; t++) m_and_act[t] = m_and_sh[t];
      for (int o = 0; o < N_OUT; o++)  m_or_act[o]  = m_or_sh[o];
      m_pol_act = m_pol_sh;
    end
    if (we) begin
      if (sel == 2'd0 && int'(addr) < N_TERM) m_and_sh[addr] = data;
      if (sel == 2'd1 && int'(addr) < N_OUT)  m_or_sh[addr]  = data[N_TERM-1:0];
      if (sel == 2'd2 && addr == 4'd0)        m_pol_sh       = data[N_OUT-1:0];
    end
    if (m_busy > 0) m_busy--;
    else if (commit) m_busy = acc ? 3 : 2;
    @(posedge clk); cyc++; @(negedge clk);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      m_last = e.val;
      chk("out_valid", bus.out_valid, 1'b1);
    end else begin
      chk("out_valid", bus.out_valid, 1'b0);
    end
    chk("out_vec", bus.out_vec, m_last);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] data);
    step(1'b0, '0, 1'b1, sel, addr, data, 1'b0);
  endtask

  task automatic send(input logic [N_IN-1:0] v);
    step(1'b1, v, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0);
  endtask

  task automatic commit_wait();
    int k;
    step(1'b0, '0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1);
    k = 0;
    while (m_busy != 0 && k < 10) begin idle(1); k++; end
    chk("commit_bound", k < 10, 1'b1);
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.in_vec = '0; bus.cfg_we = 0; bus.cfg_sel = '0;
    bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 0;
    rst = 1'b1;
    @(posedge clk); cyc++; @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_vec",   bus.out_vec,   '0);
    chk("rst_cfg_done",  bus.cfg_done,  1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
  endtask

  function automatic logic [15:0] rand_and_row();
    logic [15:0] r;
    int          x;
    r = '0;
    for (int i = 0; i < N_IN; i++) begin
      x = $urandom % 8;
      r[2*i +: 2] = (x < 4) ? 2'b00 : (x < 6) ? 2'b01 : (x < 7) ? 2'b10 : 2'b11;
    end
    return r;
  endfunction

  initial begin
    logic [1:0]  sel;
    logic [15:0] data;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    do_reset();

    // cleared config: everything evaluates 0
    send(8'hFF); idle(2);

    // out0 = in0 & in1
    wr(2'd0, 4'd0, 16'h0005); wr(2'd1, 4'd0, 16'h0001); commit_wait();
    send(8'h03); send(8'h01);
    chk("t2_first", bus.out_vec[0], 1'b1);
    idle(1);
    chk("t2_second", bus.out_vec[0], 1'b0);
    idle(2);

    // forced-zero term, then inverted polarity
    wr(2'd0, 4'd1, 16'h0003); wr(2'd1, 4'd1, 16'h0002); commit_wait();
    for (int v = 0; v < 256; v++) send(N_IN'(v));
    idle(2);
    wr(2'd2, 4'd0, 16'h0002); commit_wait();
    for (int v = 0; v < 256; v++) send(N_IN'(v));
    idle(2);

    // commit in the middle of a full-rate stream
    wr(2'd0, 4'd0, 16'h0001);
    n_lo = 0; n_done = 0;
    for (int k = 0; k < 20; k++)
      step(1'b1, N_IN'($urandom), 1'b0, 2'd0, 4'd0, 16'h0, k == 10);
    idle(4);
    chk("t4_ready_low", n_lo, 3);
    chk("t4_done_cnt", n_done, 1);

    // write landing in the copy cycle goes to the shadow only
    wr(2'd0, 4'd0, 16'h0005); commit_wait();
    step(1'b0, '0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1);
    for (int k = 0; k < 10 && m_busy != 1; k++) idle(1);
    chk("t5_in_swap", m_busy, 1);
    wr(2'd0, 4'd0, 16'h0000);
    idle(1);
    send(8'h01); idle(1);
    chk("t5_keep", bus.out_vec[0], 1'b0);
    commit_wait();
    send(8'h00); idle(1);
    chk("t5_apply", bus.out_vec[0], 1'b1);
    idle(2);

    // reset mid-drain, then ignored writes
    step(1'b1, 8'h03, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1);
    chk("t6_draining", bus.in_ready, 1'b0);
    do_reset();
    n_done = 0;
    idle(4);
    chk("t6_no_done", n_done, 0);
    wr(2'd3, 4'd0, 16'hFFFF); wr(2'd1, 4'd15, 16'hFFFF); wr(2'd2, 4'd5, 16'h0007);
    commit_wait();
    send(8'h5A); idle(1);
    chk("t6_cfg_unchanged", bus.out_vec, 3'b000);
    idle(2);

    // random traffic, config writes and commits
    for (int k = 0; k < 1500; k++) begin
      sel  = 2'($urandom % 4);
      data = (sel == 2'd0) ? rand_and_row() : 16'($urandom);
      step(($urandom % 4) != 0, N_IN'($urandom), ($urandom % 4) == 0, sel,
           4'($urandom % 16), data, ($urandom % 25) == 0);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
